// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter sharing one registered-read single-port RAM between
// instruction fetch, data load/store and a debug/boot-loader port.
module mem_port_arbiter #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned MASK_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [A_WIDTH-1:0] fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_rvalid,
  input  logic               data_req,
  input  logic [A_WIDTH-1:0] data_addr,
  input  logic [MASK_W-1:0]  data_wr_mask,
  input  logic [D_WIDTH-1:0] data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  input  logic               dbg_req,
  input  logic               dbg_lock,
  input  logic [A_WIDTH-1:0] dbg_addr,
  input  logic [MASK_W-1:0]  dbg_wr_mask,
  input  logic [D_WIDTH-1:0] dbg_wdata,
  output logic               dbg_gnt,
  output logic               dbg_rvalid,
  output logic [D_WIDTH-1:0] rdata,
  output logic               mem_en,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [MASK_W-1:0]  mem_wr_mask,
  output logic [D_WIDTH-1:0] mem_din,
  input  logic [D_WIDTH-1:0] mem_dout
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;
  typedef enum logic [1:0] {OwnFetch, OwnData, OwnDbg} owner_e;

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 rr_last_q, rr_last_d;  // 1: data was granted last
  logic                 locked_q, locked_d;
  logic [A_WIDTH-1:0]   mem_addr_q;

  logic can_issue;
  logic eff_lock;
  logic issue_read;
  logic rd_valid;

  // Lock drops in the same cycle dbg_lock is released.
  assign eff_lock  = locked_q & dbg_lock;
  assign can_issue = rst && (state_q == StIdle);

  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    dbg_gnt   = 1'b0;
    if (can_issue) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (!eff_lock) begin
        if (fetch_req && data_req) begin
          if (rr_last_q) fetch_gnt = 1'b1;
          else           data_gnt  = 1'b1;
        end else if (fetch_req) begin
          fetch_gnt = 1'b1;
        end else if (data_req) begin
          data_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_addr    = rst ? mem_addr_q : '0;
    mem_wr_mask = '0;
    mem_din     = '0;
    owner_d     = owner_q;
    if (dbg_gnt) begin
      mem_en      = 1'b1;
      mem_addr    = dbg_addr;
      mem_wr_mask = dbg_wr_mask;
      mem_din     = dbg_wdata;
      owner_d     = OwnDbg;
    end else if (data_gnt) begin
      mem_en      = 1'b1;
      mem_addr    = data_addr;
      mem_wr_mask = data_wr_mask;
      mem_din     = data_wdata;
      owner_d     = OwnData;
    end else if (fetch_gnt) begin
      mem_en      = 1'b1;
      mem_addr    = fetch_addr;
      owner_d     = OwnFetch;
    end
  end

  assign issue_read = mem_en && (mem_wr_mask == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (issue_read) state_d = StRdWait;
      StRdWait: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (fetch_gnt)     rr_last_d = 1'b0;
    else if (data_gnt) rr_last_d = 1'b1;
  end

  always_comb begin
    locked_d = locked_q;
    if (!dbg_lock)    locked_d = 1'b0;
    else if (dbg_gnt) locked_d = 1'b1;
  end

  assign rd_valid     = rst && (state_q == StRdWait);
  assign fetch_rvalid = rd_valid && (owner_q == OwnFetch);
  assign data_rvalid  = rd_valid && (owner_q == OwnData);
  assign dbg_rvalid   = rd_valid && (owner_q == OwnDbg);
  assign rdata        = rd_valid ? mem_dout : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnFetch;
      rr_last_q  <= 1'b1;
      locked_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      locked_q   <= locked_d;
      mem_addr_q <= mem_addr;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences plus a read-response
// scoreboard fed from a shadow memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, data_req, dbg_req, dbg_lock;
  logic [9:0]  fetch_addr, data_addr, dbg_addr;
  logic [3:0]  data_wr_mask, dbg_wr_mask;
  logic [31:0] data_wdata, dbg_wdata;
  logic        fetch_gnt, data_gnt, dbg_gnt;
  logic        fetch_rvalid, data_rvalid, dbg_rvalid;
  logic [31:0] rdata, mem_din, mem_dout;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wr_mask;

  logic [31:0] ram   [1024];
  logic [31:0] model [1024];

  typedef struct {
    int          owner;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_wr_mask (data_wr_mask),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .dbg_req      (dbg_req),
    .dbg_lock     (dbg_lock),
    .dbg_addr     (dbg_addr),
    .dbg_wr_mask  (dbg_wr_mask),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_wr_mask  (mem_wr_mask),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Registered-read single-port RAM with byte write mask.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_mask[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Scoreboard: grants push expected read data from the bench's own stimulus,
  // rvalids pop and compare.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      int n_gnt;
      n_gnt = int'(fetch_gnt) + int'(data_gnt) + int'(dbg_gnt);
      check_eq("gnt_onehot", 32'(n_gnt <= 1), 32'd1);
      check_eq("gnt_in_rdwait", 32'((fetch_gnt | data_gnt | dbg_gnt) &
                                    (fetch_rvalid | data_rvalid | dbg_rvalid)), 32'd0);
      if (dbg_gnt) begin
        check_eq("dbg_mem_addr", 32'(mem_addr), 32'(dbg_addr));
        if (dbg_wr_mask != 4'd0)
          model[dbg_addr] = merge(model[dbg_addr], dbg_wdata, dbg_wr_mask);
        else sb.push_back('{owner: 2, data: model[dbg_addr]});
      end else if (data_gnt) begin
        check_eq("data_mem_addr", 32'(mem_addr), 32'(data_addr));
        if (data_wr_mask != 4'd0)
          model[data_addr] = merge(model[data_addr], data_wdata, data_wr_mask);
        else sb.push_back('{owner: 1, data: model[data_addr]});
      end else if (fetch_gnt) begin
        check_eq("fetch_mem_addr", 32'(mem_addr), 32'(fetch_addr));
        check_eq("fetch_mask", 32'(mem_wr_mask), 32'd0);
        sb.push_back('{owner: 0, data: model[fetch_addr]});
      end
      if (fetch_rvalid | data_rvalid | dbg_rvalid) begin
        int got_owner;
        got_owner = fetch_rvalid ? 0 : (data_rvalid ? 1 : 2);
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check_eq("rsp_owner", 32'(got_owner), 32'(e.owner));
          check_eq("rsp_data", rdata, e.data);
        end
      end
    end
  end

  initial begin
    logic [2:0] exp_gnt [6];
    exp_gnt[0] = 3'b010; exp_gnt[1] = 3'b000; exp_gnt[2] = 3'b001;
    exp_gnt[3] = 3'b000; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b000;

    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'd0;
      model[i] = 32'd0;
    end
    ram[4]    = 32'h00A00093; model[4]  = 32'h00A00093;
    ram[16]   = 32'h11223344; model[16] = 32'h11223344;
    mem_dout  = 32'd0;

    rst = 1'b0;
    fetch_req = 1'b1; data_req = 1'b1; dbg_req = 1'b1; dbg_lock = 1'b0;
    fetch_addr = 10'h004; data_addr = 10'h010; dbg_addr = 10'h000;
    data_wr_mask = 4'd0; dbg_wr_mask = 4'd0;
    data_wdata = 32'd0; dbg_wdata = 32'd0;

    // Reset held with every request asserted.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_gnt", 32'({dbg_gnt, data_gnt, fetch_gnt}), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    end

    // First issue after reset: fetch wins the fetch/data conflict.
    next_cycle();
    rst = 1'b1; dbg_req = 1'b0;
    @(negedge clk);
    check_eq("first_gnt", 32'({dbg_gnt, data_gnt, fetch_gnt}), 32'b001);
    check_eq("fetch_addr_out", 32'(mem_addr), 32'h4);
    check_eq("fetch_mem_en", 32'(mem_en), 32'd1);
    next_cycle();
    @(negedge clk);
    check_eq("fetch_wait_gnt", 32'({dbg_gnt, data_gnt, fetch_gnt}), 32'd0);
    check_eq("fetch_rvalid", 32'(fetch_rvalid), 32'd1);
    check_eq("fetch_rdata", rdata, 32'h00A00093);

    // Continuous conflict alternates data, fetch, data at two-cycle spacing.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 5) begin
        fetch_req    = 1'b0;
        data_wr_mask = 4'b0010;
        data_wdata   = 32'h0000AB00;
      end
      @(negedge clk);
      check_eq($sformatf("rr_gnt%0d", i), 32'({dbg_gnt, data_gnt, fetch_gnt}),
               32'(exp_gnt[i]));
    end

    // Byte store, then read back the same word.
    next_cycle();
    @(negedge clk);
    check_eq("store_gnt", 32'(data_gnt), 32'd1);
    check_eq("store_mask", 32'(mem_wr_mask), 32'b0010);
    check_eq("store_din", mem_din, 32'h0000AB00);
    next_cycle();
    data_wr_mask = 4'd0;
    @(negedge clk);
    check_eq("store_no_rvalid", 32'(data_rvalid), 32'd0);
    check_eq("readback_gnt", 32'(data_gnt), 32'd1);
    next_cycle();
    data_req = 1'b0;
    @(negedge clk);
    check_eq("readback_rvalid", 32'(data_rvalid), 32'd1);
    check_eq("readback_data", rdata, 32'h1122AB44);

    // Debug lock: three back-to-back locked writes starve fetch.
    next_cycle();
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_wr_mask = 4'hF;
    dbg_addr = 10'd20; dbg_wdata = 32'hA0A00000;
    fetch_req = 1'b1; fetch_addr = 10'd20;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        next_cycle();
        dbg_addr  = 10'(20 + k);
        dbg_wdata = 32'hA0A00000 + 32'(k);
      end
      @(negedge clk);
      check_eq($sformatf("lock_dbg_gnt%0d", k), 32'(dbg_gnt), 32'd1);
      check_eq($sformatf("lock_fetch_gnt%0d", k), 32'(fetch_gnt), 32'd0);
    end
    next_cycle();
    dbg_req = 1'b0;
    @(negedge clk);
    check_eq("lock_hold", 32'(fetch_gnt), 32'd0);
    next_cycle();
    dbg_lock = 1'b0;
    @(negedge clk);
    check_eq("unlock_fetch_gnt", 32'(fetch_gnt), 32'd1);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    check_eq("unlock_rdata", rdata, 32'hA0A00000);

    // Reset while a data read is outstanding.
    next_cycle();
    data_req = 1'b1; data_addr = 10'h010; data_wr_mask = 4'd0;
    @(negedge clk);
    check_eq("mid_rd_gnt", 32'(data_gnt), 32'd1);
    next_cycle();
    data_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rd_rvalid", 32'(data_rvalid), 32'd0);
    check_eq("mid_rd_rdata", rdata, 32'd0);
    sb.delete();
    next_cycle();
    rst = 1'b1; fetch_req = 1'b1; fetch_addr = 10'h004;
    @(negedge clk);
    check_eq("post_rst_rvalid", 32'(data_rvalid), 32'd0);
    check_eq("post_rst_gnt", 32'(fetch_gnt), 32'd1);
    next_cycle();
    fetch_req = 1'b0;
    @(negedge clk);
    check_eq("post_rst_fetch_rvalid", 32'(fetch_rvalid), 32'd1);

    repeat (2) next_cycle();
    @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port BlockRAMwithMask instance (32-bit data, 10-bit word address, 4-bit byte write mask) between three requesters:
  - instruction fetch, driven by the Control_Unit PC path;
  - data load/store, driven by Data_Serialiser;
  - a debug/boot-loader port.
- Replaces the current pc_addr_en address mux with a request/grant handshake.
- Routes each registered read response back to its requester.
- Sits between those three requesters and the memory block.

Parameters:
- D_WIDTH, 32, memory data width.
- A_WIDTH, 10, word address width.
- MASK_W, 4, byte write-mask width (D_WIDTH/8).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low.
- fetch_req  in  1  fetch read request; held until fetch_gnt.
- fetch_addr  in  A_WIDTH  fetch word address.
- fetch_gnt  out  1  fetch access issued this cycle.
- fetch_rvalid  out  1  fetch read data valid this cycle.
- data_req  in  1  load/store request; held until data_gnt.
- data_addr  in  A_WIDTH  data word address.
- data_wr_mask  in  MASK_W  byte write mask; 0 = read.
- data_wdata  in  D_WIDTH  store data.
- data_gnt  out  1  data access issued this cycle.
- data_rvalid  out  1  data read data valid this cycle.
- dbg_req  in  1  debug request; held until dbg_gnt.
- dbg_lock  in  1  debug holds exclusive ownership after its first grant.
- dbg_addr  in  A_WIDTH  debug word address.
- dbg_wr_mask  in  MASK_W  byte write mask; 0 = read.
- dbg_wdata  in  D_WIDTH  debug write data.
- dbg_gnt  out  1  debug access issued this cycle.
- dbg_rvalid  out  1  debug read data valid this cycle.
- rdata  out  D_WIDTH  read data, shared by all requesters.
- mem_en  out  1  memory enable.
- mem_addr  out  A_WIDTH  memory address.
- mem_wr_mask  out  MASK_W  memory byte write mask.
- mem_din  out  D_WIDTH  memory write data.
- mem_dout  in  D_WIDTH  memory read data, registered, valid 1 cycle after mem_en.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, rr_last=DATA, locked=0.
  - All *_gnt, *_rvalid and mem_en are 0; mem_addr, mem_wr_mask, mem_din and rdata are 0.
  - A read in flight at reset is dropped; no rvalid is produced.
- States:
  - IDLE: no read outstanding; the arbiter may issue.
  - RDWAIT: one read outstanding; no issue this cycle.
- Arbitration in IDLE (combinational on req and registered state):
  - If locked: only dbg is eligible.
  - Otherwise dbg has highest priority.
  - Between fetch and data, round-robin: on conflict, grant the one not equal to rr_last.
  - rr_last updates only on fetch or data grants; reset value DATA means fetch wins the first conflict.
- Issue cycle:
  - Exactly one gnt is high; mem_en=1; mem_addr/mem_wr_mask/mem_din come from the winner.
  - Fetch always drives mask 0 and din 0.
  - With no winner: mem_en=0, mem_wr_mask=0, mem_addr holds its previous value.
- Write (winner mask != 0): completes in the issue cycle; no rvalid; next state IDLE (back-to-back writes allowed).
- Read (mask == 0):
  - Next state RDWAIT, recording the owner.
  - In RDWAIT, owner_rvalid=1 and rdata=mem_dout; then return to IDLE.
  - Read throughput is one per 2 cycles; read-to-rvalid latency is 1 cycle.
- rdata = mem_dout when any rvalid=1, else 0.
- At most one gnt and at most one rvalid per cycle; gnt is never high in RDWAIT.
- Lock:
  - locked sets on a dbg grant while dbg_lock=1.
  - locked clears in any cycle where dbg_lock=0.
  - dbg_lock without a prior dbg grant has no effect.
- Requests are level-sensitive. A requester that drops req before gnt is simply not served, with no error. A requester holding req after gnt is treated as a new request.
- Simultaneous events:
  - A req asserted in RDWAIT is considered in the following IDLE cycle.
  - A dbg_lock rising in the same cycle as the dbg grant sets locked.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all reqs=1 -> no gnt, mem_en=0, rdata=0; first cycle after rst=1 -> fetch_gnt (the round-robin reset favours fetch; dbg_req=0).
- Fetch read: fetch_req=1, fetch_addr=10'h004, memory word 4 = 32'h00A00093 -> fetch_gnt at cycle N, mem_addr=4; fetch_rvalid and rdata=32'h00A00093 at N+1; no gnt at N+1.
- Fetch/data conflict: both req continuously, data_wr_mask=0 -> grants alternate fetch, data, fetch, data at cycles N, N+2, N+4, N+6; each rvalid goes to the correct owner.
- Data byte store: data_addr=10'h010, data_wr_mask=4'b0010, data_wdata=32'h0000AB00 over word 32'h11223344 -> mem_wr_mask=4'b0010, no rvalid; a later read returns 32'h1122AB44.
- Debug lock: dbg_req with dbg_lock=1 for 3 writes while fetch_req=1 -> 3 consecutive dbg_gnt and no fetch_gnt; drop dbg_lock -> fetch_gnt next IDLE cycle.
- Reset mid-read: data read issued at N, rst=0 at N+1 -> data_rvalid never asserts and state returns to IDLE.
